periferico_bin_bcd_n: RTL and testbench
=======================================

# periferico_bin_bcd_n

Parametrised memory-mapped binary-to-BCD converter peripheral. It supports configurable operand width, digit count and bus width, plus an optional signed (two's-complement) mode. Conversion is done internally by a sequential double-dabble (shift-add-3) engine. The block sits on the processor bus next to the other calculator peripherals: software writes an operand, starts a conversion, polls status, then reads back packed BCD digits.

## Interface

Parameters:
- BIN_W, 16: operand width in bits, 4..32.
- DIGITS, 5: BCD digits produced. Must satisfy 10^DIGITS > 2^BIN_W − 1; this is the integrator's responsibility and is not checked in hardware.
- DATA_W, 32: bus data width, a multiple of 4 and ≥ BIN_W.

Ports:
- CLK, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- d_in, input, DATA_W: write data from the bus.
- cs, input, 1: chip select.
- addr, input, 6: register byte address.
- rd, input, 1: read strobe; effective only with cs.
- wr, input, 1: write strobe; effective only with cs.
- d_out, output, DATA_W: registered read data.

## Operation

Register map (unlisted addresses read 0; writes to them are ignored):
- 0x04 OP_A (R/W): operand, stored in bits [BIN_W-1:0]; upper bits read 0.
- 0x08 CTRL (W): bit0 INIT starts a conversion (self-clearing, not stored); bit1 SIGNED is the mode used by the next accepted INIT. Reading CTRL returns {0, SIGNED, 0}.
- 0x0C RES_LO (R): digits 0..DATA_W/4−1, with digit 0 in [3:0].
- 0x10 STATUS (R): bit0 DONE, bit1 BUSY, bit2 NEG, bit3 COLL.
- 0x14 RES_HI (R): remaining digits, zero-filled. Reads 0 when DIGITS ≤ DATA_W/4.

FSM states: IDLE, LOAD, SHIFT.
- **IDLE:** a write of CTRL with bit0=1 is accepted. It moves the FSM to LOAD and sets BUSY=1, DONE=0, COLL=0.
- **LOAD:** samples the current OP_A and SIGNED (register values before this edge).
  - If SIGNED=1 and OP_A[BIN_W-1]=1: magnitude = (~OP_A + 1) modulo 2^BIN_W, and NEG=1. For OP_A = 100…0 this gives magnitude 2^(BIN_W-1).
  - Otherwise magnitude = OP_A and NEG=0.
  - Clears the BCD accumulator and the iteration counter, then moves to SHIFT.
- **SHIFT:** one iteration per cycle. First add 3 to every BCD digit ≥ 5, then shift {bcd, bin} left by 1. After BIN_W iterations:
  - result register ← bcd
  - DONE=1, BUSY=0
  - state → IDLE

Further rules:
- The result register is written only on completion. Reads during a conversion return the previous result.
- NEG is updated in LOAD. It is valid whenever DONE=1.
- INIT written while BUSY is ignored and sets COLL=1. The running conversion is unaffected.
- OP_A and SIGNED may be written while BUSY. They affect only the next conversion.
- DONE is sticky and is cleared only by the next accepted INIT or by reset.

## Timing

- **Write:** registers are updated on the edge where cs && wr.
- **Read:** on the edge where cs && rd, d_out ← the selected register, so data is valid the cycle after the strobe. d_out holds its value when no read is strobed. If rd and wr are both asserted, the write takes effect and d_out shows the pre-write value.
- **Latency:** with the INIT write at edge E0:
  - LOAD occurs at E1.
  - Iterations occur at E2..E(BIN_W+1).
  - DONE=1 and the result are visible after E(BIN_W+1), i.e. BIN_W+1 cycles after the write edge (17 cycles by default).
  - BUSY=1 from after E0 through E(BIN_W).
- **Reset value of every output and register:** d_out=0, OP_A=0, SIGNED=0, result=0, DONE=BUSY=NEG=COLL=0, state=IDLE, counter=0.
- **Reset mid-conversion:** the conversion is aborted immediately (asynchronously) and no partial result is committed.
- **Back-to-back:** an INIT accepted on the same edge that completes a conversion is not possible, because BUSY is still 1 at that edge. It is treated as a collision.

## Test plan

1. **Unsigned maximum:** defaults, OP_A=0xFFFF, CTRL=0x1 → DONE=1 exactly 17 cycles later; RES_LO=0x00065535, NEG=0, RES_HI=0.
2. **Signed edge values:** CTRL=0x3 with OP_A=0x8000 → RES_LO=0x00032768, NEG=1. Then OP_A=0xFFFF, SIGNED=1 → RES_LO=0x00000001, NEG=1. Then OP_A=0x7FFF → 0x00032767, NEG=0.
3. **Collision:** OP_A=1234, INIT; after 5 cycles write OP_A=9 and INIT again → COLL=1, result 0x00001234. A subsequent INIT yields 0x00000009 with COLL cleared.
4. **Read during busy:** complete a conversion of 42, then start 999 and read RES_LO mid-conversion → returns 0x00000042 with BUSY=1. After completion the read returns 0x00000999.
5. **Reset mid-conversion:** assert reset 8 cycles after INIT → all STATUS bits 0, RES_LO=0, OP_A=0. A new INIT afterwards converts correctly.
6. **Wide instance:** BIN_W=32, DIGITS=10, OP_A=0xFFFFFFFF → DONE after 33 cycles; RES_LO=0x94967295, RES_HI=0x00000042.

Source files
------------

// File: rtl/periferico_bin_bcd_n.sv
// ---------------------------------------------------------------------------
// periferico_bin_bcd_n
//
// Memory-mapped binary-to-BCD converter peripheral. Software writes an
// operand into OP_A, pulses INIT through CTRL, polls STATUS and reads the
// packed BCD digits back from RES_LO / RES_HI. The conversion itself is a
// sequential double-dabble engine: one add-3-then-shift iteration per clock.
// An optional signed mode converts the two's-complement magnitude and
// reports the sign through STATUS.NEG.
//
// Parameters:
//   BIN_W  - operand width in bits (4..32)
//   DIGITS - number of BCD digits produced; the integrator must make sure
//            10^DIGITS exceeds the largest BIN_W-bit value
//   DATA_W - bus data width, multiple of 4 and not smaller than BIN_W
//
// Ports:
//   CLK    - single clock, all state changes on its rising edge
//   reset  - asynchronous active-high reset
//   d_in   - bus write data
//   cs     - chip select, qualifies rd and wr
//   addr   - register byte address
//   rd     - read strobe, d_out is loaded on the strobed edge
//   wr     - write strobe, registers update on the strobed edge
//   d_out  - registered read data, holds between reads
//
// Register map (byte addresses):
//   0x04 OP_A   R/W  operand in [BIN_W-1:0]
//   0x08 CTRL   W    bit0 INIT (not stored), bit1 SIGNED; reads {0,SIGNED,0}
//   0x0C RES_LO R    digits 0 .. DATA_W/4-1, digit 0 in [3:0]
//   0x10 STATUS R    bit0 DONE, bit1 BUSY, bit2 NEG, bit3 COLL
//   0x14 RES_HI R    remaining digits, zero filled
// ---------------------------------------------------------------------------
module periferico_bin_bcd_n #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [DATA_W-1:0] d_in,
  input  logic              cs,
  input  logic [5:0]        addr,
  input  logic              rd,
  input  logic              wr,
  output logic [DATA_W-1:0] d_out
);

  // Register addresses.
  localparam logic [5:0] ADDR_OP_A   = 6'h04;
  localparam logic [5:0] ADDR_CTRL   = 6'h08;
  localparam logic [5:0] ADDR_RES_LO = 6'h0C;
  localparam logic [5:0] ADDR_STATUS = 6'h10;
  localparam logic [5:0] ADDR_RES_HI = 6'h14;

  // Converter states.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  // Width of the packed BCD result.
  localparam int RES_W = 4 * DIGITS;

  // The result is zero-extended to at least two bus words so that RES_LO
  // and RES_HI can always be sliced out, whatever DIGITS is.
  localparam int EXT_W = (RES_W > 2 * DATA_W) ? RES_W : 2 * DATA_W;

  // Iteration counter runs 0 .. BIN_W-1.
  localparam int              CNT_W     = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  // Architectural registers.
  logic [1:0]       state;
  logic [BIN_W-1:0] op_a;
  logic             signed_mode;
  logic [RES_W-1:0] result;
  logic             done;
  logic             busy;
  logic             neg;
  logic             coll;

  // Double-dabble working registers.
  logic [CNT_W-1:0] iter;
  logic [BIN_W-1:0] bin_sr;
  logic [RES_W-1:0] bcd_sr;

  // Combinational helpers.
  logic              wr_en;
  logic              rd_en;
  logic              init_req;
  logic              take_neg;
  logic [BIN_W-1:0]  magnitude;
  logic [RES_W-1:0]  bcd_adj;
  logic [RES_W-1:0]  bcd_next;
  logic [EXT_W-1:0]  res_ext;
  logic [DATA_W-1:0] rd_data;
  logic              unused_bits;

  // Bus strobes only count while the peripheral is selected. INIT is a
  // pulse carried by a CTRL write with bit0 set; it is never stored.
  always_comb begin
    wr_en    = cs && wr;
    rd_en    = cs && rd;
    init_req = wr_en && (addr == ADDR_CTRL) && d_in[0];
  end

  // Magnitude of the operand as seen by the LOAD step. In signed mode a
  // negative operand is negated modulo 2^BIN_W, which makes the most
  // negative value map onto 2^(BIN_W-1) without any special case.
  always_comb begin
    take_neg  = signed_mode && op_a[BIN_W-1];
    magnitude = take_neg ? (~op_a + BIN_W'(1)) : op_a;
  end

  // Add-3 correction: every digit that is 5 or more would overflow past 9
  // when doubled by the following shift, so it is pre-biased by 3.
  always_comb begin
    bcd_adj = bcd_sr;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
      end
    end
  end

  // One double-dabble step: the corrected BCD digits shift left and take
  // the next binary MSB as their new LSB.
  always_comb begin
    bcd_next = {bcd_adj[RES_W-2:0], bin_sr[BIN_W-1]};
  end

  // Software-visible configuration registers. They may be rewritten while
  // a conversion runs; the engine copies what it needs in LOAD, so a
  // rewrite only affects the following conversion.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      op_a        <= '0;
      signed_mode <= 1'b0;
    end else if (wr_en) begin
      if (addr == ADDR_OP_A) begin
        op_a <= d_in[BIN_W-1:0];
      end
      if (addr == ADDR_CTRL) begin
        signed_mode <= d_in[1];
      end
    end
  end

  // Conversion sequencer and status flags. BUSY simply mirrors "not idle".
  // An INIT arriving while not idle (including the completing edge) is
  // dropped and only raises COLL. DONE stays set until the next accepted
  // INIT. The result register is touched only on the final iteration, so
  // software keeps seeing the previous result while a new one is computed,
  // and an asynchronous reset in the middle never exposes a partial value.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      result <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
      neg    <= 1'b0;
      coll   <= 1'b0;
      iter   <= '0;
      bin_sr <= '0;
      bcd_sr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (init_req) begin
            state <= ST_LOAD;
            busy  <= 1'b1;
            done  <= 1'b0;
            coll  <= 1'b0;
          end
        end

        ST_LOAD: begin
          if (init_req) begin
            coll <= 1'b1;
          end
          neg    <= take_neg;
          bin_sr <= magnitude;
          bcd_sr <= '0;
          iter   <= '0;
          state  <= ST_SHIFT;
        end

        ST_SHIFT: begin
          if (init_req) begin
            coll <= 1'b1;
          end
          bcd_sr <= bcd_next;
          bin_sr <= bin_sr << 1;
          iter   <= iter + CNT_W'(1);
          if (iter == LAST_ITER) begin
            result <= bcd_next;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Read multiplexer. Unmapped addresses read as zero.
  always_comb begin
    res_ext = EXT_W'(result);
    rd_data = '0;
    case (addr)
      ADDR_OP_A:   rd_data[BIN_W-1:0] = op_a;
      ADDR_CTRL:   rd_data[1]         = signed_mode;
      ADDR_RES_LO: rd_data            = res_ext[DATA_W-1:0];
      ADDR_STATUS: rd_data[3:0]       = {coll, neg, busy, done};
      ADDR_RES_HI: rd_data            = res_ext[2*DATA_W-1:DATA_W];
      default:     rd_data            = '0;
    endcase
  end

  // Registered read port. Because the mux looks at pre-edge register
  // values, a simultaneous read and write returns the old contents.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      d_out <= '0;
    end else if (rd_en) begin
      d_out <= rd_data;
    end
  end

  // Operand bits beyond BIN_W, CTRL bits beyond SIGNED and any result
  // extension beyond two bus words are intentionally ignored.
  assign unused_bits = ^{d_in, res_ext};

endmodule

// File: tb/tb_periferico_bin_bcd_n.sv
// ---------------------------------------------------------------------------
// tb_periferico_bin_bcd_n
//
// Drives a default instance (16-bit operand, 5 digits) and a wide instance
// (32-bit operand, 10 digits) on a shared clock. A register-level model of
// the peripheral computes the expected read data from plain decimal
// arithmetic; every cycle the registered read data of both instances is
// compared with it. Directed sequences with hand-computed values pin the
// model, then a long randomised bus phase exercises both instances.
// ---------------------------------------------------------------------------
module tb_periferico_bin_bcd_n;

  localparam logic [5:0] A_OP_A   = 6'h04;
  localparam logic [5:0] A_CTRL   = 6'h08;
  localparam logic [5:0] A_RES_LO = 6'h0C;
  localparam logic [5:0] A_STATUS = 6'h10;
  localparam logic [5:0] A_RES_HI = 6'h14;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs[2];
  logic        rd[2];
  logic        wr[2];
  logic [5:0]  addr[2];
  logic [31:0] d_in[2];
  logic [31:0] d_out[2];

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Reference model state, one slot per instance.
  logic [63:0] m_op[2]     = '{64'd0, 64'd0};
  bit          m_sgn[2]    = '{1'b0, 1'b0};
  logic [63:0] m_res[2]    = '{64'd0, 64'd0};
  logic [63:0] m_mag[2]    = '{64'd0, 64'd0};
  bit          m_done[2]   = '{1'b0, 1'b0};
  bit          m_busy[2]   = '{1'b0, 1'b0};
  bit          m_neg[2]    = '{1'b0, 1'b0};
  bit          m_coll[2]   = '{1'b0, 1'b0};
  int          m_remain[2] = '{0, 0};
  logic [31:0] exp_dout[2] = '{32'd0, 32'd0};

  periferico_bin_bcd_n u_dut_std (
    .CLK   (clk),
    .reset (reset),
    .d_in  (d_in[0]),
    .cs    (cs[0]),
    .addr  (addr[0]),
    .rd    (rd[0]),
    .wr    (wr[0]),
    .d_out (d_out[0])
  );

  periferico_bin_bcd_n #(
    .BIN_W  (32),
    .DIGITS (10),
    .DATA_W (32)
  ) u_dut_wide (
    .CLK   (clk),
    .reset (reset),
    .d_in  (d_in[1]),
    .cs    (cs[1]),
    .addr  (addr[1]),
    .rd    (rd[1]),
    .wr    (wr[1]),
    .d_out (d_out[1])
  );

  initial forever #5 clk = ~clk;

  // Decimal digits of v packed four bits per digit, least significant first.
  function automatic logic [63:0] to_bcd(input logic [63:0] v, input int n);
    logic [63:0] r;
    logic [63:0] x;
    r = '0;
    x = v;
    for (int i = 0; i < n; i++) begin
      r[4*i +: 4] = 4'(x % 64'd10);
      x = x / 64'd10;
    end
    return r;
  endfunction

  function automatic logic [31:0] model_read(input int k, input logic [5:0] a);
    case (a)
      A_OP_A:   return m_op[k][31:0];
      A_CTRL:   return {30'd0, m_sgn[k], 1'b0};
      A_RES_LO: return m_res[k][31:0];
      A_STATUS: return {28'd0, m_coll[k], m_neg[k], m_busy[k], m_done[k]};
      A_RES_HI: return m_res[k][63:32];
      default:  return 32'd0;
    endcase
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_op[k] = '0; m_sgn[k] = 1'b0; m_res[k] = '0; m_mag[k] = '0;
      m_done[k] = 1'b0; m_busy[k] = 1'b0; m_neg[k] = 1'b0; m_coll[k] = 1'b0;
      m_remain[k] = 0; exp_dout[k] = '0;
    end
  endtask

  // One clock edge of the model: reads see pre-edge state, the running
  // conversion finishes BIN_W+1 edges after its INIT, then writes apply.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int          bw;
      int          nd;
      bit          was_busy;
      logic [63:0] mask;
      bw       = (k == 0) ? 16 : 32;
      nd       = (k == 0) ? 5 : 10;
      mask     = (64'd1 << bw) - 64'd1;
      was_busy = m_busy[k];
      if (cs[k] && rd[k]) exp_dout[k] = model_read(k, addr[k]);
      if (was_busy) begin
        if (m_remain[k] == bw + 1) begin
          if (m_sgn[k] && m_op[k][bw-1]) begin
            m_mag[k] = (64'd1 << bw) - m_op[k];
            m_neg[k] = 1'b1;
          end else begin
            m_mag[k] = m_op[k];
            m_neg[k] = 1'b0;
          end
        end
        m_remain[k] = m_remain[k] - 1;
        if (m_remain[k] == 0) begin
          m_res[k]  = to_bcd(m_mag[k], nd);
          m_done[k] = 1'b1;
          m_busy[k] = 1'b0;
        end
      end
      if (cs[k] && wr[k]) begin
        if (addr[k] == A_OP_A) m_op[k] = {32'd0, d_in[k]} & mask;
        if (addr[k] == A_CTRL) begin
          m_sgn[k] = d_in[k][1];
          if (d_in[k][0]) begin
            if (was_busy) begin
              m_coll[k] = 1'b1;
            end else begin
              m_busy[k]   = 1'b1;
              m_done[k]   = 1'b0;
              m_coll[k]   = 1'b0;
              m_remain[k] = bw + 1;
            end
          end
        end
      end
    end
  endtask

  initial begin : model_proc
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_clear();
      else model_step();
    end
  end

  // Continuous comparison of both read ports against the model.
  initial begin : compare_proc
    forever begin
      @(negedge clk);
      if (cmp_en && !reset) begin
        for (int k = 0; k < 2; k++) begin
          checks++;
          if (d_out[k] !== exp_dout[k]) begin
            errors++;
            $display("[TB] FAIL model_dout inst%0d at %0t: got 0x%08h expected 0x%08h",
                     k, $time, d_out[k], exp_dout[k]);
          end
        end
      end
    end
  end

  task automatic set_idle();
    for (int k = 0; k < 2; k++) begin
      cs[k] = 1'b0; rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; d_in[k] = '0;
    end
  endtask

  // One bus cycle on instance k, the other instance idle.
  task automatic applyStimulus(input int k, input logic c, input logic r, input logic w,
                               input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    set_idle();
    cs[k] = c; rd[k] = r; wr[k] = w; addr[k] = a; d_in[k] = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      set_idle();
    end
  endtask

  task automatic do_write(input int k, input logic [5:0] a, input logic [31:0] d);
    applyStimulus(k, 1'b1, 1'b0, 1'b1, a, d);
  endtask

  task automatic checkOutput(input int k, input string name, input logic [5:0] a,
                             input logic [31:0] expected);
    applyStimulus(k, 1'b1, 1'b1, 1'b0, a, 32'd0);
    @(negedge clk);
    set_idle();
    checks++;
    if (d_out[k] !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, d_out[k], expected);
    end
  endtask

  // Called right after the INIT write: reads STATUS every cycle and
  // counts reads until DONE shows. DONE is set on edge BIN_W+1 after the
  // write, so it first appears in the read strobed on edge BIN_W+2.
  task automatic poll_done(input int k, input string name, input int expected_reads);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      set_idle();
      cs[k] = 1'b1; rd[k] = 1'b1; addr[k] = A_STATUS;
      n++;
      @(posedge clk);
      #1;
      if (d_out[k][0]) seen = 1'b1;
    end
    idle(1);
    checks++;
    if (n != expected_reads || !seen) begin
      errors++;
      $display("[TB] FAIL %s: done seen after %0d reads (seen=%0d) expected %0d",
               name, n, seen, expected_reads);
    end
  endtask

  task automatic convert(input int k, input logic [31:0] op, input logic [31:0] ctrl);
    do_write(k, A_OP_A, op);
    do_write(k, A_CTRL, ctrl);
    idle(40);
  endtask

  logic [5:0] addr_tbl[6] = '{A_OP_A, A_CTRL, A_RES_LO, A_STATUS, A_RES_HI, 6'h00};

  task automatic random_cycle();
    @(negedge clk);
    set_idle();
    for (int k = 0; k < 2; k++) begin
      int sel;
      int bw;
      bw     = (k == 0) ? 16 : 32;
      cs[k]  = ($urandom_range(0, 3) != 0);
      rd[k]  = $urandom_range(0, 1) == 1;
      wr[k]  = ($urandom_range(0, 2) == 0);
      sel    = $urandom_range(0, 5);
      addr[k] = (sel == 5) ? 6'($urandom_range(0, 63)) : addr_tbl[sel];
      case ($urandom_range(0, 3))
        0: d_in[k] = 32'd0;
        1: d_in[k] = 32'hFFFF_FFFF;
        2: d_in[k] = 32'd1 << (bw - 1);
        default: d_in[k] = $urandom;
      endcase
      if (addr[k] == A_CTRL) d_in[k] = {$urandom_range(0, 7) == 0 ? 30'h1 : 30'h0,
                                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
    end
  endtask

  initial begin : main
    reset = 1'b1;
    set_idle();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    cmp_en = 1'b1;

    // Reset state.
    checkOutput(0, "reset_status", A_STATUS, 32'h0);
    checkOutput(0, "reset_res_lo", A_RES_LO, 32'h0);
    checkOutput(0, "reset_op_a", A_OP_A, 32'h0);
    checkOutput(1, "reset_wide_res_hi", A_RES_HI, 32'h0);

    // Unsigned maximum and completion latency.
    do_write(0, A_OP_A, 32'h0000_FFFF);
    do_write(0, A_CTRL, 32'h1);
    poll_done(0, "latency_16", 18);
    checkOutput(0, "umax_res_lo", A_RES_LO, 32'h0006_5535);
    checkOutput(0, "umax_status", A_STATUS, 32'h1);
    checkOutput(0, "umax_res_hi", A_RES_HI, 32'h0);

    // Signed edge values.
    convert(0, 32'h8000, 32'h3);
    checkOutput(0, "s8000_res_lo", A_RES_LO, 32'h0003_2768);
    checkOutput(0, "s8000_status", A_STATUS, 32'h5);
    checkOutput(0, "ctrl_readback", A_CTRL, 32'h2);
    convert(0, 32'hFFFF, 32'h3);
    checkOutput(0, "sffff_res_lo", A_RES_LO, 32'h0000_0001);
    checkOutput(0, "sffff_status", A_STATUS, 32'h5);
    convert(0, 32'h7FFF, 32'h3);
    checkOutput(0, "s7fff_res_lo", A_RES_LO, 32'h0003_2767);
    checkOutput(0, "s7fff_status", A_STATUS, 32'h1);

    // Collision: second INIT during a conversion is dropped.
    do_write(0, A_OP_A, 32'd1234);
    do_write(0, A_CTRL, 32'h1);
    idle(5);
    do_write(0, A_OP_A, 32'd9);
    do_write(0, A_CTRL, 32'h1);
    idle(25);
    checkOutput(0, "coll_res_lo", A_RES_LO, 32'h0000_1234);
    checkOutput(0, "coll_status", A_STATUS, 32'h9);
    do_write(0, A_CTRL, 32'h1);
    idle(25);
    checkOutput(0, "after_coll_res_lo", A_RES_LO, 32'h0000_0009);
    checkOutput(0, "after_coll_status", A_STATUS, 32'h1);

    // Read during busy returns the previous result.
    convert(0, 32'd42, 32'h1);
    checkOutput(0, "res_42", A_RES_LO, 32'h0000_0042);
    do_write(0, A_OP_A, 32'd999);
    do_write(0, A_CTRL, 32'h1);
    idle(4);
    checkOutput(0, "busy_res_lo", A_RES_LO, 32'h0000_0042);
    checkOutput(0, "busy_status", A_STATUS, 32'h2);
    idle(25);
    checkOutput(0, "res_999", A_RES_LO, 32'h0000_0999);

    // Reset in the middle of a conversion.
    do_write(0, A_OP_A, 32'd555);
    do_write(0, A_CTRL, 32'h1);
    idle(7);
    @(posedge clk);
    #3 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    set_idle();
    checkOutput(0, "midrst_status", A_STATUS, 32'h0);
    checkOutput(0, "midrst_res_lo", A_RES_LO, 32'h0);
    checkOutput(0, "midrst_op_a", A_OP_A, 32'h0);
    convert(0, 32'd77, 32'h1);
    checkOutput(0, "postrst_res_lo", A_RES_LO, 32'h0000_0077);

    // Wide instance.
    do_write(1, A_OP_A, 32'hFFFF_FFFF);
    do_write(1, A_CTRL, 32'h1);
    poll_done(1, "latency_32", 34);
    checkOutput(1, "wide_res_lo", A_RES_LO, 32'h9496_7295);
    checkOutput(1, "wide_res_hi", A_RES_HI, 32'h0000_0042);
    convert(1, 32'h8000_0000, 32'h3);
    checkOutput(1, "wide_neg_res_lo", A_RES_LO, 32'h4748_3648);
    checkOutput(1, "wide_neg_res_hi", A_RES_HI, 32'h0000_0021);
    checkOutput(1, "wide_neg_status", A_STATUS, 32'h5);

    // Randomised bus traffic on both instances.
    repeat (4000) random_cycle();
    idle(40);
    for (int k = 0; k < 2; k++) begin
      checkOutput(k, "final_status", A_STATUS, model_read(k, A_STATUS));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
